// File: rtl/dec6b4b_pkg.sv
// Shared constants for the 6b/4b serial receiver: SYNC word, code table, decoder.
package dec6b4b_pkg;

  typedef enum logic {
    ST_HUNT   = 1'b0,
    ST_LOCKED = 1'b1
  } rx_state_e;

  localparam logic [5:0] SYNC_WORD = 6'b000111;

  // Packed so that CODE_TABLE[n] is the codeword for nibble n (entry F listed first).
  localparam logic [15:0][5:0] CODE_TABLE = {
    6'b110010, 6'b110001, 6'b101100, 6'b101010,
    6'b101001, 6'b100110, 6'b100101, 6'b100011,
    6'b011100, 6'b011010, 6'b011001, 6'b010110,
    6'b010101, 6'b010011, 6'b001110, 6'b001101
  };

  function automatic logic [4:0] decode6b(input logic [5:0] word);
    logic [4:0] res;
    res = 5'b0;
    for (int i = 0; i < 16; i++) begin
      if (CODE_TABLE[i] == word) res = {1'b1, 4'(i)};
    end
    return res;
  endfunction

endpackage

// File: rtl/dec6b4b_fifo.sv
// Small valid/ready FIFO holding decoded nibbles; DEPTH must be a power of two.
module dec6b4b_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             full_o,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  input  logic             ready_i
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             pop, wr;

  assign valid_o = (cnt_q != '0);
  assign full_o  = (cnt_q == FULL_CNT);
  assign data_o  = mem_q[rd_ptr_q];
  assign pop     = valid_o & ready_i;
  // A pop in the same cycle frees the head slot, so a push into a full FIFO still lands.
  assign wr      = push_i & (~full_o | pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr)  wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
    cnt_d = cnt_q + CW'(wr) - CW'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/dec6b4b_rx.sv
// 6b/4b serial receiver: SYNC hunt/lock FSM, word decode and output FIFO.
// Optional DEC6B4B_ERRCNT_EN adds the saturating err_cnt output.
module dec6b4b_rx
  import dec6b4b_pkg::*;
#(
  parameter int MAX_ERR    = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sdi,
  input  logic       sdi_en,
  output logic [3:0] o_data,
  output logic       o_valid,
  input  logic       o_ready,
  output logic       locked,
  output logic       code_err,
  output logic       ovf
`ifdef DEC6B4B_ERRCNT_EN
  ,
  output logic [7:0] err_cnt
`endif
);

  localparam logic [3:0] MAX_ERR_C = 4'(MAX_ERR);

  rx_state_e  state_q, state_d;
  logic [5:0] shift_q, shift_d, shift_nxt;
  logic [2:0] bitcnt_q, bitcnt_d;
  logic [3:0] cerr_q, cerr_d;
  logic       push_q, push_d;
  logic [3:0] pdata_q, pdata_d;
  logic       code_err_q, code_err_d;
  logic       ovf_q, ovf_d;
  logic [4:0] dec;
  logic       fifo_full;
`ifdef DEC6B4B_ERRCNT_EN
  logic [7:0] errcnt_q, errcnt_d;
  assign err_cnt = errcnt_q;
`endif

  assign locked   = (state_q == ST_LOCKED);
  assign code_err = code_err_q;
  assign ovf      = ovf_q;

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bitcnt_d   = bitcnt_q;
    cerr_d     = cerr_q;
    push_d     = 1'b0;
    pdata_d    = pdata_q;
    code_err_d = 1'b0;
    ovf_d      = ovf_q | (push_q & fifo_full & ~(o_valid & o_ready));
    shift_nxt  = {shift_q[4:0], sdi};
    dec        = decode6b(shift_nxt);
`ifdef DEC6B4B_ERRCNT_EN
    errcnt_d   = errcnt_q;
`endif
    if (sdi_en) begin
      shift_d = shift_nxt;
      case (state_q)
        ST_HUNT: begin
          if (shift_nxt == SYNC_WORD) begin
            state_d  = ST_LOCKED;
            bitcnt_d = 3'd0;
            cerr_d   = 4'd0;
          end
        end
        default: begin
          if (bitcnt_q == 3'd5) begin
            bitcnt_d = 3'd0;
            if (dec[4]) begin
              push_d  = 1'b1;
              pdata_d = dec[3:0];
              cerr_d  = 4'd0;
            end else if (shift_nxt == SYNC_WORD) begin
              cerr_d = 4'd0;
            end else begin
              code_err_d = 1'b1;
`ifdef DEC6B4B_ERRCNT_EN
              if (errcnt_q != 8'hFF) errcnt_d = errcnt_q + 8'd1;
`endif
              if (cerr_q + 4'd1 >= MAX_ERR_C) begin
                state_d = ST_HUNT;
                cerr_d  = 4'd0;
              end else begin
                cerr_d = cerr_q + 4'd1;
              end
            end
          end else begin
            bitcnt_d = bitcnt_q + 3'd1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_HUNT;
      shift_q    <= '0;
      bitcnt_q   <= '0;
      cerr_q     <= '0;
      push_q     <= 1'b0;
      code_err_q <= 1'b0;
      ovf_q      <= 1'b0;
`ifdef DEC6B4B_ERRCNT_EN
      errcnt_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bitcnt_q   <= bitcnt_d;
      cerr_q     <= cerr_d;
      push_q     <= push_d;
      code_err_q <= code_err_d;
      ovf_q      <= ovf_d;
`ifdef DEC6B4B_ERRCNT_EN
      errcnt_q   <= errcnt_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    pdata_q <= pdata_d;
  end

  dec6b4b_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(4)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push_i (push_q),
    .data_i (pdata_q),
    .full_o (fifo_full),
    .data_o (o_data),
    .valid_o(o_valid),
    .ready_i(o_ready)
  );

endmodule

// File: tb/tb_dec6b4b_rx.sv
// Scoreboard bench for dec6b4b_rx: directed serial words, queued expected nibbles.
module tb_dec6b4b_rx;

  logic       clk = 1'b0;
  logic       rst_n, sdi, sdi_en, o_ready;
  logic [3:0] o_data;
  logic       o_valid, locked, code_err, ovf;
`ifdef DEC6B4B_ERRCNT_EN
  logic [7:0] err_cnt;
`endif

  int         n_checks = 0;
  int         n_fail   = 0;
  int         n_cerr   = 0;
  logic [3:0] exp_q[$];

  always #5 clk = ~clk;

  dec6b4b_rx #(.MAX_ERR(4), .FIFO_DEPTH(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .sdi     (sdi),
    .sdi_en  (sdi_en),
    .o_data  (o_data),
    .o_valid (o_valid),
    .o_ready (o_ready),
    .locked  (locked),
    .code_err(code_err),
    .ovf     (ovf)
`ifdef DEC6B4B_ERRCNT_EN
    ,
    .err_cnt (err_cnt)
`endif
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input int gap);
    sdi_en = 1'b0;
    repeat (gap) tick();
    sdi    = b;
    sdi_en = 1'b1;
    tick();
    sdi_en = 1'b0;
  endtask

  task automatic send_word(input logic [5:0] w, input int gap);
    for (int i = 5; i >= 0; i--) send_bit(w[i], gap);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) tick();
    check(name, exp_q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_o_valid"}, int'(o_valid), 0);
    check({tag, "_locked"}, int'(locked), 0);
    check({tag, "_code_err"}, int'(code_err), 0);
    check({tag, "_ovf"}, int'(ovf), 0);
`ifdef DEC6B4B_ERRCNT_EN
    check({tag, "_err_cnt"}, int'(err_cnt), 0);
`endif
  endtask

  task automatic monitor();
    logic [3:0] exp;
    forever begin
      @(negedge clk);
      if (code_err) n_cerr++;
      if (o_valid && o_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL spurious_output: got nibble %0h, required no output", o_data);
        end else begin
          exp = exp_q.pop_front();
          check("scoreboard_data", int'(o_data), int'(exp));
        end
      end
    end
  endtask

  initial begin
    int cerr_base;
    rst_n = 1'b0; sdi = 1'b0; sdi_en = 1'b0; o_ready = 1'b0;
    fork
      monitor();
    join_none
    repeat (3) tick();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick();

    // Lock then decode 0x0 and 0xF with the consumer always ready
    o_ready = 1'b1;
    send_word(6'b000111, 0);
    check("lock_after_sync", int'(locked), 1);
    exp_q.push_back(4'h0);
    send_word(6'b001101, 0);
    check("latency_early", int'(o_valid), 0);
    tick();
    check("latency_valid", int'(o_valid), 1);
    check("latency_data", int'(o_data), 0);
    exp_q.push_back(4'hF);
    send_word(6'b110010, 0);
    drain("drain_basic");
    check("no_code_err_basic", n_cerr, 0);

    // Four invalid words force loss of lock
    cerr_base = n_cerr;
    for (int k = 0; k < 3; k++) send_word(6'b111111, 0);
    check("still_locked_3err", int'(locked), 1);
    send_word(6'b111111, 0);
    check("unlock_4err", int'(locked), 0);
    tick(); tick();
    check("code_err_pulses", n_cerr - cerr_base, 4);
`ifdef DEC6B4B_ERRCNT_EN
    check("err_cnt_4", int'(err_cnt), 4);
`endif

    // Overflow: five words into a depth-4 FIFO with consumer stalled
    send_word(6'b000111, 0);
    check("relock", int'(locked), 1);
    o_ready = 1'b0;
    exp_q.push_back(4'h1); send_word(6'b001110, 0);
    exp_q.push_back(4'h2); send_word(6'b010011, 0);
    exp_q.push_back(4'h3); send_word(6'b010101, 0);
    exp_q.push_back(4'h4); send_word(6'b010110, 0);
    tick(); tick();
    check("ovf_before_5th", int'(ovf), 0);
    send_word(6'b011001, 0);
    tick(); tick();
    check("ovf_set", int'(ovf), 1);
    check("hold_valid", int'(o_valid), 1);
    check("hold_data", int'(o_data), 1);
    o_ready = 1'b1;
    drain("drain_ovf");
    check("ovf_sticky", int'(ovf), 1);

    // Full FIFO with a pop in the push cycle: no overflow
    rst_n = 1'b0;
    tick();
    check_reset_outputs("reset2");
    rst_n = 1'b1;
    tick();
    send_word(6'b000111, 0);
    o_ready = 1'b0;
    exp_q.push_back(4'h6); send_word(6'b011010, 0);
    exp_q.push_back(4'h7); send_word(6'b011100, 0);
    exp_q.push_back(4'h8); send_word(6'b100011, 0);
    exp_q.push_back(4'h9); send_word(6'b100101, 0);
    tick(); tick();
    exp_q.push_back(4'hA); send_word(6'b100110, 0);
    o_ready = 1'b1;
    drain("drain_full_pop");
    check("no_ovf_pop_push", int'(ovf), 0);

    // Reset mid-word, then data without SYNC must produce nothing
    send_bit(1'b0, 0); send_bit(1'b1, 0); send_bit(1'b0, 0);
    rst_n = 1'b0;
    #2;
    check_reset_outputs("reset_mid");
    tick();
    rst_n = 1'b1;
    send_word(6'b001101, 0);
    send_word(6'b010101, 0);
    tick(); tick();
    check("no_lock_wo_sync", int'(locked), 0);
    check("no_data_wo_sync", int'(o_valid), 0);

    // Idle gaps between strobes decode identically to back-to-back
    send_word(6'b000111, 1);
    exp_q.push_back(4'h3);
    for (int i = 5; i >= 0; i--) send_bit(1'(6'b010101 >> i), i % 4);
    exp_q.push_back(4'h3);
    send_word(6'b010101, 0);
    exp_q.push_back(4'hC);
    send_word(6'b101010, 3);
    drain("drain_gaps");
    check("no_code_err_gaps", n_cerr - cerr_base, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
